grid_renderer: RTL
==================

Name: grid_renderer

Overview:
- Reads the 160x120 game grid one row at a time and turns it into single-pixel writes for the vga_adapter (x, y, colour, plot).
- It is the consumer of the grid that the shifter grid produces. It is triggered once per frame after gridUpdateEn.
- The grid source returns one row per request with a fixed 1-cycle read latency. The renderer owns the row address and a local row buffer.

Parameters:
- WIDTH, 160, pixels per row; also the row_data width.
- HEIGHT, 120, rows per frame.
- FG_COLOUR, 3'b111, colour plotted for a set grid bit.
- BG_COLOUR, 3'b000, colour plotted for a clear grid bit.

Ports:
- clock  in  1  system clock (50 MHz); all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- start  in  1  request a frame render; sampled only in IDLE.
- row_rd  out  1  row read strobe; one cycle per row.
- row_addr  out  7  row index being requested, 0..HEIGHT-1.
- row_data  in  WIDTH  row contents, valid the cycle after row_rd; bit k is pixel x=k.
- x  out  8  pixel column to vga_adapter.
- y  out  7  pixel row to vga_adapter.
- colour  out  3  pixel colour to vga_adapter.
- plot  out  1  write enable to vga_adapter; one pixel per cycle while high.
- busy  out  1  high from the cycle after start is accepted through the DONE state.
- done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset values (asynchronous, active-high): state=IDLE; x=0, y=0, colour=0, plot=0, row_rd=0, row_addr=0, busy=0, done=0; row buffer cleared.
- States:
  - IDLE: if start=1, set y=0 and go to FETCH. Otherwise stay.
  - FETCH: row_rd=1, row_addr=y (one cycle). Go to WAIT.
  - WAIT: row_rd=0. At the end of this cycle, latch row_data into the row buffer and set x=0. Go to DRAW.
  - DRAW: plot=1 with the current x and y; colour = buf[x] ? FG_COLOUR : BG_COLOUR. Increment x each cycle.
    - When x=WIDTH-1: if y=HEIGHT-1, go to DONE; else y<=y+1 and go to FETCH.
  - DONE: done=1, plot=0 for one cycle. Go to IDLE.
- x, y, colour and plot are registered, so they change together and the adapter sees a consistent tuple each cycle.
- Cost per row: WIDTH+2 cycles. Frame latency from start sampled to done pulse is 1 + HEIGHT*(WIDTH+2) cycles; with defaults that is 19441.
- busy=1 in FETCH, WAIT, DRAW and DONE; 0 in IDLE.
- plot=0 in IDLE, FETCH, WAIT and DONE.
- start while busy is ignored, with no queuing. start held high in IDLE after DONE begins a new frame immediately.
- Counter widths: x never exceeds WIDTH-1 and y never exceeds HEIGHT-1. There is no wrap past the last pixel; the frame terminates.
- row_data is ignored except in WAIT. Changes to the grid during DRAW do not affect the current row.
- Reset mid-frame: outputs go to their reset values without waiting for a clock edge, and the FSM returns to IDLE. The next frame starts only on a fresh start.

Optional Feature:
- Macro: GRID_RENDERER_SKIP_EMPTY_EN
- Defined: in WAIT, if row_data==0, skip DRAW for that row and advance directly (y+1 to FETCH, or DONE on the last row). plot is never asserted for that row.
  - An empty row costs 2 cycles.
  - The caller must guarantee the screen was already cleared to BG_COLOUR.
- Undefined: every row is fully drawn; latency is fixed at 1 + HEIGHT*(WIDTH+2).

Test Plan:
- Reset with all-zero grid, pulse start -> exactly 19200 plot cycles, all with colour=000. done pulses at cycle 19441 after start; busy deasserts the following cycle.
- Grid with only row 119 bit 37 set -> exactly one plot with colour=111, at x=37, y=119. All other plots are 000.
- Read timing check -> row_rd is high exactly once per row with row_addr 0..119 in order. The first plot of row r occurs 2 cycles after its row_rd.
- start pulsed again at cycle 5000 mid-frame -> ignored; total plots remain 19200 and a single done pulse.
- Assert reset at cycle 8000 mid-DRAW -> plot, busy and row_rd drop without waiting for a clock edge. No further plots until a new start, which restarts at x=0, y=0.
- With GRID_RENDERER_SKIP_EMPTY_EN and only row 10 non-zero (bits 0 and 159 set) -> 160 plots, all at y=10, colour 111 at x=0 and x=159. done arrives 1 + 119*2 + 162 = 401 cycles after start.

Source files
------------

// File: rtl/grid_renderer_if.sv
// Grid renderer bus: row-read port toward the grid source, pixel port toward the VGA adapter.
// master = renderer side; slave = grid source / adapter / controller side.
// row_data is WIDTH bits wide; the coordinate widths fit the 160x120 screen.
interface grid_renderer_if #(
    parameter int WIDTH = 160
);
    logic             start;
    logic             row_rd;
    logic [6:0]       row_addr;
    logic [WIDTH-1:0] row_data;
    logic [7:0]       x;
    logic [6:0]       y;
    logic [2:0]       colour;
    logic             plot;
    logic             busy;
    logic             done;

    modport master (
        input  start, row_data,
        output row_rd, row_addr, x, y, colour, plot, busy, done
    );

    modport slave (
        output start, row_data,
        input  row_rd, row_addr, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/grid_renderer.sv
// Grid renderer: fetches the game grid row by row and emits one pixel write per cycle.
// Latency: start -> done is 1 + HEIGHT*(WIDTH+2) cycles; each row costs FETCH + WAIT + WIDTH draw cycles.
// No backpressure: the adapter must accept a pixel every cycle plot is high; start while busy is dropped.
// Optional: define GRID_RENDERER_SKIP_EMPTY_EN to skip drawing all-zero rows (2 cycles per empty row).
module grid_renderer #(
    parameter int         WIDTH     = 160,
    parameter int         HEIGHT    = 120,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic          clock,
    input  logic          reset,
    grid_renderer_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_buf;
    logic [7:0]       r_x;
    logic [6:0]       r_y;
    logic [2:0]       r_colour;
    logic             r_plot;
    logic             r_row_rd;
    logic [6:0]       r_row_addr;
    logic             r_busy;
    logic             r_done;

    logic [7:0]       w_x_nxt;
    logic [6:0]       w_y_nxt;
    logic             w_last_row;
    logic             w_skip_row;

    assign w_x_nxt    = r_x + 8'd1;
    assign w_y_nxt    = r_y + 7'd1;
    assign w_last_row = (r_y == Y_LAST);

`ifdef GRID_RENDERER_SKIP_EMPTY_EN
    // An all-zero row needs no pixels: the screen is assumed already cleared to background.
    assign w_skip_row = (bus.row_data == '0);
`else
    assign w_skip_row = 1'b0;
`endif

    // Frame sequencer; every output is a register so the adapter sees a consistent x/y/colour/plot tuple.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
            r_plot     <= 1'b0;
            r_row_rd   <= 1'b0;
            r_row_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Strobes default low; states raise them for exactly the cycles they apply.
            r_row_rd <= 1'b0;
            r_plot   <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_y        <= '0;
                        r_row_addr <= '0;
                        r_row_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Grid data arrives now; latch it so later grid updates cannot tear this row.
                    r_buf <= bus.row_data;
                    if (w_skip_row) begin
                        if (w_last_row) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_y        <= w_y_nxt;
                            r_row_addr <= w_y_nxt;
                            r_row_rd   <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end else begin
                        // First pixel reads row_data directly since the buffer is loaded on this same edge.
                        r_x      <= '0;
                        r_colour <= bus.row_data[0] ? FG_COLOUR : BG_COLOUR;
                        r_plot   <= 1'b1;
                        r_state  <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (r_x == X_LAST) begin
                        if (w_last_row) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_y        <= w_y_nxt;
                            r_row_addr <= w_y_nxt;
                            r_row_rd   <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end else begin
                        r_x      <= w_x_nxt;
                        r_colour <= r_buf[w_x_nxt] ? FG_COLOUR : BG_COLOUR;
                        r_plot   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.row_rd   = r_row_rd;
    assign bus.row_addr = r_row_addr;
    assign bus.x        = r_x;
    assign bus.y        = r_y;
    assign bus.colour   = r_colour;
    assign bus.plot     = r_plot;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
